uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 139 +++++++++++++
 tb/tb_uart_tx_framed.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: buffered UART transmitter.
// Small FIFO feeding a serializer with optional parity and 1-2 stop bits.
module uart_tx_framed #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk1,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 push;
  logic                 pop;
  logic                 have;
  logic                 bit_end;
  logic                 stop_last;
  logic [DATA_BITS-1:0] head;

  assign tx_ready  = (fifo_level != FULL);
  assign push      = tx_valid & tx_ready;
  assign have      = (fifo_level != '0);
  assign bit_end   = (cnt == CMAX);
  assign stop_last = (STOP_BITS == 1) | stop_idx;
  assign head      = mem[rd_ptr];

  // Pop from idle, or on the last stop edge for a gapless next frame
  assign pop = have & ((state == IDLE) |
               ((state == STOP) & bit_end & stop_last));

  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      cnt <= (bit_end || state == IDLE) ? '0 : cnt + CW'(1);
      if (pop) begin
        state   <= START;
        tx      <= 1'b0;
        busy    <= 1'b1;
        cnt     <= '0;
        shreg   <= head;
        par_bit <= (PARITY == 1) ? ~^head : ^head;
      end else begin
        unique case (state)
          IDLE: ;
          START: if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
          DATA: if (bit_end) begin
            if (bit_idx != BMAX) begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end else if (PARITY != 0) begin
              state <= PAR;
              tx    <= par_bit;
            end else begin
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
            end
          end
          PAR: if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
          STOP: if (bit_end) begin
            if (!stop_last) begin
              stop_idx <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: directed bench with frame-decoding scoreboard.
// Instance a: even parity, 1 stop; instance b: odd parity, 2 stops.
module tb_uart_tx_framed;

  localparam int CD = 4;
  localparam int NA = 11;
  localparam int NB = 12;

  logic       clk1;
  logic       rst;
  logic       va, vb;
  logic [7:0] da, db;
  logic       ra, rb;
  logic       txa, txb;
  logic       busya, busyb;
  logic [2:0] lvla, lvlb;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  uart_tx_framed #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk1(clk1), .rst(rst),
    .tx_valid(va), .tx_data(da),
    .tx_ready(ra), .tx(txa),
    .busy(busya), .fifo_level(lvla)
  );

  uart_tx_framed #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk1(clk1), .rst(rst),
    .tx_valid(vb), .tx_data(db),
    .tx_ready(rb), .tx(txb),
    .busy(busyb), .fifo_level(lvlb)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-bit sampling monitors; a frame is popped from the scoreboard on its last stop bit
  int         ca = 0;
  bit         act_a = 1'b0;
  logic [10:0] fa;
  logic [7:0] ea;

  always @(negedge clk1) begin
    if (!rst) act_a = 1'b0;
    else begin
      if (!act_a && txa === 1'b0) begin
        act_a = 1'b1;
        ca = 0;
      end
      if (act_a) begin
        if (ca % CD == CD / 2) begin
          fa[ca / CD] = txa;
          chk("busy_a", busya, 1);
        end
        if (ca == NA * CD - CD / 2) begin
          if (qa.size() == 0) chk("extra_frame_a", 1, 0);
          else begin
            ea = qa.pop_front();
            chk("frame_a", fa, {1'b1, ^ea, ea, 1'b0});
          end
        end
        ca++;
        if (ca == NA * CD) act_a = 1'b0;
      end
    end
  end

  int         cb = 0;
  bit         act_b = 1'b0;
  logic [11:0] fb;
  logic [7:0] eb;

  always @(negedge clk1) begin
    if (!rst) act_b = 1'b0;
    else begin
      if (!act_b && txb === 1'b0) begin
        act_b = 1'b1;
        cb = 0;
      end
      if (act_b) begin
        if (cb % CD == CD / 2) begin
          fb[cb / CD] = txb;
          chk("busy_b", busyb, 1);
        end
        if (cb == NB * CD - CD / 2) begin
          if (qb.size() == 0) chk("extra_frame_b", 1, 0);
          else begin
            eb = qb.pop_front();
            chk("frame_b", fb, {2'b11, ~^eb, eb, 1'b0});
          end
        end
        cb++;
        if (cb == NB * CD) act_b = 1'b0;
      end
    end
  end

  task automatic push_a(input logic [7:0] d);
    @(negedge clk1);
    va = 1'b1;
    da = d;
    qa.push_back(d);
    @(negedge clk1);
    va = 1'b0;
  endtask

  task automatic drain_a(output int n);
    n = 0;
    while (busya === 1'b1 && n < 300) begin
      @(negedge clk1);
      n++;
    end
  endtask

  task automatic drain_b(output int n);
    n = 0;
    while (busyb === 1'b1 && n < 300) begin
      @(negedge clk1);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n;
  int bc;

  initial begin
    rst = 1'b1;
    va = 1'b0; da = '0;
    vb = 1'b0; db = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_tx_a", txa, 1);
    chk("rst_ready_a", ra, 1);
    chk("rst_busy_a", busya, 0);
    chk("rst_level_a", lvla, 0);
    chk("rst_tx_b", txb, 1);
    chk("rst_level_b", lvlb, 0);
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b1;

    // single even-parity frame
    push_a(8'hA5);
    chk("a5_level", lvla, 1);
    chk("a5_idle_tx", txa, 1);
    chk("a5_idle_busy", busya, 0);
    @(negedge clk1);
    chk("a5_start_tx", txa, 0);
    chk("a5_start_busy", busya, 1);
    chk("a5_pop_level", lvla, 0);
    drain_a(n);
    chk("a5_cycles", n, 44);
    chk("a5_sb_empty", qa.size(), 0);

    // odd parity, two stop bits
    @(negedge clk1);
    vb = 1'b1; db = 8'h00; qb.push_back(8'h00);
    @(negedge clk1);
    vb = 1'b0;
    @(negedge clk1);
    chk("b00_start_tx", txb, 0);
    drain_b(n);
    chk("b00_cycles", n, 48);
    chk("b00_sb_empty", qb.size(), 0);

    // burst until full
    bc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk1);
      bc += int'(busya);
      chk("burst_ready", ra, (i < 5) ? 1 : 0);
      va = 1'b1;
      da = 8'h10 + i[7:0];
      if (i < 5) qa.push_back(8'h10 + i[7:0]);
    end
    @(negedge clk1);
    va = 1'b0;
    chk("burst_level", lvla, 4);
    chk("burst_full_ready", ra, 0);
    drain_a(n);
    chk("burst_cycles", bc + n, 220);
    chk("burst_sb_empty", qa.size(), 0);
    chk("burst_end_level", lvla, 0);

    // push on the frame-end pop edge
    @(negedge clk1);
    va = 1'b1; da = 8'h66; qa.push_back(8'h66);
    @(negedge clk1);
    va = 1'b0;
    @(negedge clk1);
    va = 1'b1; da = 8'h99; qa.push_back(8'h99);
    @(negedge clk1);
    va = 1'b0;
    chk("mid_level", lvla, 1);
    repeat (42) @(negedge clk1);
    chk("pre_pop_tx", txa, 1);
    chk("pre_pop_level", lvla, 1);
    va = 1'b1; da = 8'hC3; qa.push_back(8'hC3);
    @(negedge clk1);
    va = 1'b0;
    chk("pushpop_level", lvla, 1);
    chk("b2b_start_tx", txa, 0);
    chk("b2b_busy", busya, 1);
    drain_a(n);
    chk("pushpop_cycles", n, 88);
    chk("pushpop_sb_empty", qa.size(), 0);

    // reset during the third data bit
    push_a(8'hFB);
    @(negedge clk1);
    va = 1'b1; da = 8'h11; qa.push_back(8'h11);
    @(negedge clk1);
    da = 8'h22; qa.push_back(8'h22);
    @(negedge clk1);
    va = 1'b0;
    chk("prerst_level", lvla, 2);
    repeat (11) @(negedge clk1);
    chk("prerst_bit2", txa, 0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_tx", txa, 1);
    chk("midrst_level", lvla, 0);
    chk("midrst_ready", ra, 1);
    chk("midrst_busy", busya, 0);
    qa.delete();
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b1;
    push_a(8'h3C);
    @(negedge clk1);
    chk("post_rst_start", txa, 0);
    drain_a(n);
    chk("post_rst_cycles", n, 44);
    repeat (60) @(negedge clk1);
    chk("post_rst_idle_busy", busya, 0);
    chk("post_rst_idle_tx", txa, 1);
    chk("post_rst_level", lvla, 0);
    chk("post_rst_sb_empty", qa.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
